qspi_flash_target: RTL and testbench

Synthesizable QSPI flash responder: the device-side end of the link driven by the team's `qspi_fsm` controller. It oversamples SCLK/CS#/IO with the system clock, decodes opcode, address and dummy phases, serves reads from and accepts page-program writes into an attached byte-wide memory port, and drives IO lanes back during data-out phases. Used as an on-chip loopback target for controller verification and FPGA bring-up.

---
 rtl/qspi_pkg.sv | 38 +++
 rtl/qspi_edge_sync.sv | 50 +++++
 rtl/qspi_flash_target.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_qspi_flash_target.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/qspi_pkg.sv
// Shared definitions for the QSPI flash responder: opcodes, FSM states and lane-mode encoding.
package qspi_pkg;

  localparam logic [7:0] OP_PP   = 8'h02;
  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_WRDI = 8'h04;
  localparam logic [7:0] OP_RDSR = 8'h05;
  localparam logic [7:0] OP_WREN = 8'h06;
  localparam logic [7:0] OP_FAST = 8'h0B;
  localparam logic [7:0] OP_DUAL = 8'h3B;
  localparam logic [7:0] OP_QUAD = 8'h6B;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_DOUT,
    ST_DIN,
    ST_IGNORE
  } state_t;

  // Same encoding as the controller's *_lanes_sel fields.
  typedef enum logic [1:0] {
    LANES_1 = 2'd0,
    LANES_2 = 2'd1,
    LANES_4 = 2'd2
  } lanes_t;

  function automatic logic [3:0] lane_count(input lanes_t mode);
    case (mode)
      LANES_2: lane_count = 4'd2;
      LANES_4: lane_count = 4'd4;
      default: lane_count = 4'd1;
    endcase
  endfunction

endpackage

// File: rtl/qspi_edge_sync.sv
// Pad synchronizers: sclk/cs_n get 2 flops plus an edge-detect flop, io lanes get 2 flops.
module qspi_edge_sync (
  input  logic       clk,
  input  logic       resetn,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic [3:0] io_in,
  output logic       sclk_rise,
  output logic       sclk_fall,
  output logic       cs_rise,
  output logic       cs_fall,
  output logic [3:0] io_s
);

  // [0] metastable stage, [1] synchronized, [2] previous synchronized value
  logic [2:0] sclk_pipe;
  logic [2:0] cs_pipe;
  logic [3:0] io_meta;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sclk_pipe <= 3'b000;
      cs_pipe   <= 3'b111;
    end else begin
      sclk_pipe <= {sclk_pipe[1:0], sclk};
      cs_pipe   <= {cs_pipe[1:0], cs_n};
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_io_sync
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          io_meta[gi] <= 1'b0;
          io_s[gi]    <= 1'b0;
        end else begin
          io_meta[gi] <= io_in[gi];
          io_s[gi]    <= io_meta[gi];
        end
      end
    end
  endgenerate

  assign sclk_rise = sclk_pipe[1] & ~sclk_pipe[2];
  assign sclk_fall = ~sclk_pipe[1] & sclk_pipe[2];
  assign cs_rise   = cs_pipe[1] & ~cs_pipe[2];
  assign cs_fall   = ~cs_pipe[1] & cs_pipe[2];

endmodule

// File: rtl/qspi_flash_target.sv
// Oversampling QSPI flash responder serving READ/FAST/DUAL/RDSR/WREN/WRDI/PP against a byte memory port.
// Define QSPI_FLASH_TARGET_QUAD_EN to decode 0x6B as a quad output read.
module qspi_flash_target
  import qspi_pkg::*;
#(
  parameter int unsigned ADDR_W     = 24,
  parameter int unsigned DUMMY_FAST = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic [3:0]        io_in,
  output logic [3:0]        io_out,
  output logic [3:0]        io_oe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  output logic              wel
);

  localparam logic [7:0]        DUMMY_LAST = 8'(DUMMY_FAST - 1);
  localparam logic [ADDR_W-1:0] PAGE_MASK  = ADDR_W'(8'hFF);

  logic       sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [3:0] io_s;
  logic       unused_io;

  state_t              state_reg, state_next;
  logic [7:0]          cnt_reg, cnt_next;
  logic [7:0]          shift_reg, shift_next;
  logic [7:0]          op_reg, op_next;
  lanes_t              lanes_reg, lanes_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [7:0]          prefetch_reg, prefetch_next;
  logic                rd_pend_reg, rd_pend_next;
  logic                wel_reg, wel_next;
  logic                wrote_reg, wrote_next;
  logic [3:0]          io_out_reg, io_out_next;
  logic [3:0]          io_oe_reg, io_oe_next;
  logic                mem_re_reg, mem_re_next;
  logic                mem_we_reg, mem_we_next;
  logic [7:0]          mem_wdata_reg, mem_wdata_next;
  logic [ADDR_W-1:0]   mem_addr_reg, mem_addr_next;

  logic [7:0]          rx_byte;
  logic [ADDR_W-1:0]   addr_shift, addr_inc, addr_page_inc;
  logic [7:0]          byte_v, remain_v;

  qspi_edge_sync u_sync (
    .clk       (clk),
    .resetn    (resetn),
    .sclk      (sclk),
    .cs_n      (cs_n),
    .io_in     (io_in),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .cs_rise   (cs_rise),
    .cs_fall   (cs_fall),
    .io_s      (io_s)
  );

  // Only single-lane input phases exist, so io1..io3 are never sampled.
  assign unused_io     = ^io_s[3:1];
  assign rx_byte       = {shift_reg[6:0], io_s[0]};
  assign addr_shift    = {addr_reg[ADDR_W-2:0], io_s[0]};
  assign addr_inc      = addr_reg + ADDR_W'(1);
  assign addr_page_inc = (addr_reg & ~PAGE_MASK) | (addr_inc & PAGE_MASK);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_reg <= ST_IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (cs_rise) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: if (cs_fall) state_next = ST_CMD;
        ST_CMD: begin
          if (sclk_rise && cnt_reg == 8'd7) begin
            case (rx_byte)
              OP_RDSR:                            state_next = ST_DOUT;
              OP_READ, OP_FAST, OP_DUAL, OP_PP:   state_next = ST_ADDR;
`ifdef QSPI_FLASH_TARGET_QUAD_EN
              OP_QUAD:                            state_next = ST_ADDR;
`endif
              default:                            state_next = ST_IGNORE;
            endcase
          end
        end
        ST_ADDR: begin
          if (sclk_rise && cnt_reg == 8'd23) begin
            if (op_reg == OP_READ)    state_next = ST_DOUT;
            else if (op_reg == OP_PP) state_next = ST_DIN;
            else                      state_next = ST_DUMMY;
          end
        end
        ST_DUMMY: if (sclk_rise && cnt_reg == DUMMY_LAST) state_next = ST_DOUT;
        default:  state_next = state_reg;
      endcase
    end
  end

  always_comb begin
    cnt_next       = cnt_reg;
    shift_next     = shift_reg;
    op_next        = op_reg;
    lanes_next     = lanes_reg;
    addr_next      = addr_reg;
    prefetch_next  = prefetch_reg;
    rd_pend_next   = mem_re_reg;
    wel_next       = wel_reg;
    wrote_next     = wrote_reg;
    io_out_next    = io_out_reg;
    io_oe_next     = io_oe_reg;
    mem_re_next    = 1'b0;
    mem_we_next    = 1'b0;
    mem_wdata_next = mem_wdata_reg;
    mem_addr_next  = mem_addr_reg;
    byte_v         = 8'h00;
    remain_v       = 8'h00;

    if (rd_pend_reg) prefetch_next = mem_rdata;

    case (state_reg)
      ST_IDLE: begin
        if (cs_fall) begin
          cnt_next    = 8'd0;
          shift_next  = 8'h00;
          wrote_next  = 1'b0;
          io_out_next = 4'h0;
          io_oe_next  = 4'h0;
        end
      end
      ST_CMD: begin
        if (sclk_rise && !cs_rise) begin
          shift_next = rx_byte;
          cnt_next   = cnt_reg + 8'd1;
          if (cnt_reg == 8'd7) begin
            cnt_next   = 8'd0;
            op_next    = rx_byte;
            lanes_next = LANES_1;
            if (rx_byte == OP_WREN) wel_next = 1'b1;
            if (rx_byte == OP_WRDI) wel_next = 1'b0;
            if (rx_byte == OP_DUAL) lanes_next = LANES_2;
`ifdef QSPI_FLASH_TARGET_QUAD_EN
            if (rx_byte == OP_QUAD) lanes_next = LANES_4;
`endif
          end
        end
      end
      ST_ADDR: begin
        if (sclk_rise && !cs_rise) begin
          addr_next = addr_shift;
          cnt_next  = cnt_reg + 8'd1;
          if (cnt_reg == 8'd23) begin
            cnt_next = 8'd0;
            if (op_reg != OP_PP) begin
              mem_re_next   = 1'b1;
              mem_addr_next = addr_shift;
            end
          end
        end
      end
      ST_DUMMY: begin
        if (sclk_rise && !cs_rise) begin
          cnt_next = (cnt_reg == DUMMY_LAST) ? 8'd0 : cnt_reg + 8'd1;
        end
      end
      ST_DOUT: begin
        if (sclk_fall && !cs_rise) begin
          // cnt_reg counts bits left in the current byte; zero means load the next one.
          if (cnt_reg == 8'd0) begin
            remain_v = 8'd8;
            if (op_reg == OP_RDSR) begin
              byte_v = {6'b000000, wel_reg, 1'b0};
            end else begin
              byte_v        = prefetch_reg;
              addr_next     = addr_inc;
              mem_re_next   = 1'b1;
              mem_addr_next = addr_inc;
            end
          end else begin
            remain_v = cnt_reg;
            byte_v   = shift_reg;
          end
          shift_next = byte_v << lane_count(lanes_reg);
          cnt_next   = remain_v - 8'(lane_count(lanes_reg));
          case (lanes_reg)
            LANES_2: begin
              io_out_next = {2'b00, byte_v[7:6]};
              io_oe_next  = 4'b0011;
            end
            LANES_4: begin
              io_out_next = byte_v[7:4];
              io_oe_next  = 4'b1111;
            end
            default: begin
              io_out_next = {3'b000, byte_v[7]};
              io_oe_next  = 4'b0001;
            end
          endcase
        end
      end
      ST_DIN: begin
        // Not gated by cs_rise: a byte whose last rise coincides with CS# rise still completes.
        if (sclk_rise) begin
          shift_next = rx_byte;
          cnt_next   = cnt_reg + 8'd1;
          if (cnt_reg == 8'd7) begin
            cnt_next  = 8'd0;
            addr_next = addr_page_inc;
            if (wel_reg) begin
              mem_we_next    = 1'b1;
              mem_wdata_next = rx_byte;
              mem_addr_next  = addr_reg;
              wrote_next     = 1'b1;
            end
          end
        end
      end
      default: begin
      end
    endcase

    if (cs_rise) begin
      cnt_next    = 8'd0;
      io_out_next = 4'h0;
      io_oe_next  = 4'h0;
      if (state_reg == ST_DIN && wrote_next) wel_next = 1'b0;
    end

`ifndef QSPI_FLASH_TARGET_QUAD_EN
    io_out_next[3:2] = 2'b00;
    io_oe_next[3:2]  = 2'b00;
`endif
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_reg       <= 8'd0;
      shift_reg     <= 8'h00;
      op_reg        <= 8'h00;
      lanes_reg     <= LANES_1;
      addr_reg      <= '0;
      prefetch_reg  <= 8'h00;
      rd_pend_reg   <= 1'b0;
      wel_reg       <= 1'b0;
      wrote_reg     <= 1'b0;
      io_out_reg    <= 4'h0;
      io_oe_reg     <= 4'h0;
      mem_re_reg    <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_wdata_reg <= 8'h00;
      mem_addr_reg  <= '0;
    end else begin
      cnt_reg       <= cnt_next;
      shift_reg     <= shift_next;
      op_reg        <= op_next;
      lanes_reg     <= lanes_next;
      addr_reg      <= addr_next;
      prefetch_reg  <= prefetch_next;
      rd_pend_reg   <= rd_pend_next;
      wel_reg       <= wel_next;
      wrote_reg     <= wrote_next;
      io_out_reg    <= io_out_next;
      io_oe_reg     <= io_oe_next;
      mem_re_reg    <= mem_re_next;
      mem_we_reg    <= mem_we_next;
      mem_wdata_reg <= mem_wdata_next;
      mem_addr_reg  <= mem_addr_next;
    end
  end

  assign io_out    = io_out_reg;
  assign io_oe     = io_oe_reg;
  assign mem_re    = mem_re_reg;
  assign mem_we    = mem_we_reg;
  assign mem_wdata = mem_wdata_reg;
  assign mem_addr  = mem_addr_reg;
  assign wel       = wel_reg;

endmodule

// File: tb/tb_qspi_flash_target.sv
// Directed bench for qspi_flash_target: bit-banged mode-0 controller plus a registered-read memory model.
module tb_qspi_flash_target;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        sclk = 1'b0;
  logic        cs_n = 1'b1;
  logic [3:0]  io_drv = 4'h0;
  logic [3:0]  io_out, io_oe;
  logic [23:0] mem_addr;
  logic        mem_re, mem_we, wel;
  logic [7:0]  mem_rdata, mem_wdata;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem [0:255];
  int          re_cnt = 0;
  int          we_cnt = 0;
  logic [23:0] re_log [0:63];
  logic [23:0] we_addr_log [0:63];
  logic [7:0]  we_data_log [0:63];
  logic        oe_hi_seen = 1'b0;

  qspi_flash_target dut (
    .clk       (clk),
    .resetn    (resetn),
    .sclk      (sclk),
    .cs_n      (cs_n),
    .io_in     (io_drv),
    .io_out    (io_out),
    .io_oe     (io_oe),
    .mem_addr  (mem_addr),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .wel       (wel)
  );

  always #5 clk = ~clk;

  // Memory model: contents indexed by the low address byte, read data one clk after mem_re.
  always @(posedge clk) begin
    if (mem_re) begin
      mem_rdata <= mem[mem_addr[7:0]];
      re_log[re_cnt[5:0]] <= mem_addr;
      re_cnt <= re_cnt + 1;
    end
    if (mem_we) begin
      we_addr_log[we_cnt[5:0]] <= mem_addr;
      we_data_log[we_cnt[5:0]] <= mem_wdata;
      we_cnt <= we_cnt + 1;
    end
    if (|io_oe[3:2]) oe_hi_seen <= 1'b1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic [3:0] drv, output logic [3:0] o, output logic [3:0] e);
    io_drv = drv;
    #60;
    o = io_out;
    e = io_oe;
    sclk = 1'b1;
    #60;
    sclk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic [3:0] o, e;
    for (int i = 7; i >= 0; i--) pulse({3'b000, b[i]}, o, e);
  endtask

  task automatic read_byte(input int lanes, output logic [7:0] b,
                           output logic [3:0] out_first, output logic [3:0] oe_first);
    logic [3:0] o, e;
    b = 8'h00;
    out_first = 4'h0;
    oe_first = 4'h0;
    for (int i = 0; i < 8 / lanes; i++) begin
      pulse(4'h0, o, e);
      if (i == 0) begin
        out_first = o;
        oe_first = e;
      end
      case (lanes)
        1:       b = {b[6:0], o[0]};
        2:       b = {b[5:0], o[1:0]};
        default: b = {b[3:0], o};
      endcase
    end
  endtask

  task automatic idle_pulses(input int n, output logic [3:0] oe_or);
    logic [3:0] o, e;
    oe_or = 4'h0;
    for (int i = 0; i < n; i++) begin
      pulse(4'h0, o, e);
      oe_or = oe_or | e;
    end
  endtask

  task automatic cs_start();
    cs_n = 1'b0;
    #50;
  endtask

  task automatic cs_end();
    #40;
    cs_n = 1'b1;
    #80;
  endtask

  task automatic send_addr(input logic [23:0] a);
    send_byte(a[23:16]);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
  endtask

  initial begin
    logic [7:0] b0, b1, b2;
    logic [3:0] of, ef, oe_or;
    int base;

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'hA5;
    mem[8'h11] = 8'h3C;
    mem[8'h12] = 8'hF0;
    mem[8'hFF] = 8'h5A;
    mem[8'h00] = 8'hC3;
    mem[8'h20] = 8'hAB;
    mem[8'h40] = 8'h96;

    #20;
    chk("rst_io_out", {28'h0, io_out}, 32'h0);
    chk("rst_io_oe", {28'h0, io_oe}, 32'h0);
    chk("rst_mem_re", {31'h0, mem_re}, 32'h0);
    chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
    chk("rst_mem_wdata", {24'h0, mem_wdata}, 32'h0);
    chk("rst_mem_addr", {8'h0, mem_addr}, 32'h0);
    chk("rst_wel", {31'h0, wel}, 32'h0);
    #20 resetn = 1'b1;
    #100;

    cs_start(); send_byte(8'h06); cs_end();
    chk("wren_wel", {31'h0, wel}, 32'h1);
    cs_start(); send_byte(8'h05); read_byte(1, b0, of, ef); cs_end();
    chk("rdsr_after_wren", {24'h0, b0}, 32'h02);
    $display("txn WREN+RDSR status=%h", b0);

    cs_start(); send_byte(8'h04); cs_end();
    chk("wrdi_wel", {31'h0, wel}, 32'h0);
    cs_start(); send_byte(8'h05); read_byte(1, b0, of, ef); cs_end();
    chk("rdsr_after_wrdi", {24'h0, b0}, 32'h00);
    $display("txn WRDI+RDSR status=%h", b0);

    base = re_cnt;
    cs_start(); send_byte(8'h03); send_addr(24'h000010);
    read_byte(1, b0, of, ef); read_byte(1, b1, of, ef); read_byte(1, b2, of, ef);
    cs_end();
    chk("read_b0", {24'h0, b0}, 32'hA5);
    chk("read_b1", {24'h0, b1}, 32'h3C);
    chk("read_b2", {24'h0, b2}, 32'hF0);
    chk("read_re0", {8'h0, re_log[6'(base)]}, 32'h000010);
    chk("read_re1", {8'h0, re_log[6'(base + 1)]}, 32'h000011);
    chk("read_re2", {8'h0, re_log[6'(base + 2)]}, 32'h000012);
    chk("read_oe_end", {28'h0, io_oe}, 32'h0);
    $display("txn READ 0x000010 data=%h %h %h", b0, b1, b2);

    base = re_cnt;
    cs_start(); send_byte(8'h0B); send_addr(24'hFFFFFF);
    idle_pulses(8, oe_or);
    read_byte(1, b0, of, ef); read_byte(1, b1, of, ef);
    cs_end();
    chk("fast_dummy_oe", {28'h0, oe_or}, 32'h0);
    chk("fast_b0", {24'h0, b0}, 32'h5A);
    chk("fast_b1", {24'h0, b1}, 32'hC3);
    chk("fast_re0", {8'h0, re_log[6'(base)]}, 32'hFFFFFF);
    chk("fast_re1", {8'h0, re_log[6'(base + 1)]}, 32'h000000);
    $display("txn FAST 0xFFFFFF data=%h %h", b0, b1);

    cs_start(); send_byte(8'h3B); send_addr(24'h000020);
    idle_pulses(8, oe_or);
    read_byte(2, b0, of, ef);
    cs_end();
    chk("dual_first_pair", {30'h0, of[1:0]}, 32'h2);
    chk("dual_oe", {28'h0, ef}, 32'h3);
    chk("dual_byte", {24'h0, b0}, 32'hAB);
    $display("txn DUAL 0x000020 data=%h", b0);

    base = we_cnt;
    cs_start(); send_byte(8'h02); send_addr(24'h000030); send_byte(8'h55); cs_end();
    chk("pp_nowren_we", base, we_cnt);
    $display("txn PP without WREN writes=%0d", we_cnt - base);

    cs_start(); send_byte(8'h06); cs_end();
    base = we_cnt;
    cs_start(); send_byte(8'h02); send_addr(24'h0000FF);
    send_byte(8'h11); send_byte(8'h22); cs_end();
    chk("pp_we_count", we_cnt - base, 32'd2);
    chk("pp_addr0", {8'h0, we_addr_log[6'(base)]}, 32'h0000FF);
    chk("pp_data0", {24'h0, we_data_log[6'(base)]}, 32'h11);
    chk("pp_addr1", {8'h0, we_addr_log[6'(base + 1)]}, 32'h000000);
    chk("pp_data1", {24'h0, we_data_log[6'(base + 1)]}, 32'h22);
    chk("pp_wel_cleared", {31'h0, wel}, 32'h0);
    $display("txn PP 0x0000FF writes=%0d", we_cnt - base);

    base = re_cnt;
    cs_start(); send_byte(8'h03); idle_pulses(5, oe_or); cs_end();
    chk("abort_no_re", re_cnt - base, 32'd0);
    chk("abort_oe", {28'h0, io_oe}, 32'h0);
    cs_start(); send_byte(8'h05); read_byte(1, b0, of, ef); cs_end();
    chk("abort_then_rdsr", {24'h0, b0}, 32'h00);
    $display("txn READ aborted after 5 address bits");

`ifdef QSPI_FLASH_TARGET_QUAD_EN
    cs_start(); send_byte(8'h6B); send_addr(24'h000040);
    idle_pulses(8, oe_or);
    read_byte(4, b0, of, ef);
    cs_end();
    chk("quad_oe", {28'h0, ef}, 32'hF);
    chk("quad_byte", {24'h0, b0}, 32'h96);
    $display("txn QUAD 0x000040 data=%h", b0);
`else
    base = re_cnt;
    cs_start(); send_byte(8'h6B); idle_pulses(48, oe_or); cs_end();
    chk("quad_off_oe", {28'h0, oe_or}, 32'h0);
    chk("quad_off_no_re", re_cnt - base, 32'd0);
    chk("quad_off_hi_lanes", {31'h0, oe_hi_seen}, 32'h0);
    $display("txn 0x6B ignored");
`endif

    cs_start(); send_byte(8'h06); cs_end();
    chk("rst_pre_wel", {31'h0, wel}, 32'h1);
    cs_start(); send_byte(8'h03); send_byte(8'h00);
    resetn = 1'b0;
    #30;
    chk("midrst_wel", {31'h0, wel}, 32'h0);
    chk("midrst_oe", {28'h0, io_oe}, 32'h0);
    chk("midrst_addr", {8'h0, mem_addr}, 32'h0);
    cs_n = 1'b1;
    #20 resetn = 1'b1;
    #100;
    cs_start(); send_byte(8'h05); read_byte(1, b0, of, ef); cs_end();
    chk("midrst_rdsr", {24'h0, b0}, 32'h00);
    $display("txn reset mid-READ status=%h", b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
